// File: rtl/wb_initiator.sv
// Wishbone classic initiator: turns a command (start address, beat count, fill data)
// into single-beat bus cycles with a per-beat response stream and an ack timeout.
module wb_initiator #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_we,
   input  logic [31:0] cmd_adr,
   input  logic [31:0] cmd_dat,
   input  logic [3:0]  cmd_sel,
   input  logic [7:0]  cmd_len,
   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   output logic        wbm_we_o,
   output logic [3:0]  wbm_sel_o,
   output logic [31:0] wbm_adr_o,
   output logic [31:0] wbm_dat_o,
   input  logic [31:0] wbm_dat_i,
   input  logic        wbm_ack_i,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_dat,
   output logic        rsp_err,
   output logic        rsp_last,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      RSP  = 2'd2
   } state_t;

   localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

   state_t      state;
   state_t      state_nxt;
   logic [7:0]  beat_cnt;
   logic [15:0] wait_cnt;
   logic        timeout_hit;

   assign timeout_hit = (wait_cnt == WAIT_LAST);

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Ack takes priority over timeout, so an ack on the last allowed cycle is a normal beat.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (cmd_valid) state_nxt = BUS;
         BUS:  if (wbm_ack_i || timeout_hit) state_nxt = RSP;
         RSP:  if (rsp_ready) state_nxt = rsp_last ? IDLE : BUS;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      cmd_ready = (state == IDLE);
      rsp_valid = (state == RSP);
      busy      = (state != IDLE);
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         wbm_cyc_o <= 1'b0;
         wbm_stb_o <= 1'b0;
         wbm_we_o  <= 1'b0;
         wbm_sel_o <= '0;
         wbm_adr_o <= '0;
         wbm_dat_o <= '0;
         rsp_dat   <= '0;
         rsp_err   <= 1'b0;
         rsp_last  <= 1'b0;
         beat_cnt  <= '0;
         wait_cnt  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  wbm_adr_o <= cmd_adr;
                  wbm_we_o  <= cmd_we;
                  wbm_sel_o <= cmd_sel;
                  wbm_dat_o <= cmd_dat;
                  beat_cnt  <= cmd_len;
                  wait_cnt  <= '0;
                  wbm_cyc_o <= 1'b1;
                  wbm_stb_o <= 1'b1;
               end
            end
            BUS: begin
               if (wbm_ack_i) begin
                  wbm_cyc_o <= 1'b0;
                  wbm_stb_o <= 1'b0;
                  rsp_dat   <= wbm_we_o ? 32'd0 : wbm_dat_i;
                  rsp_err   <= 1'b0;
                  rsp_last  <= (beat_cnt == 8'd0);
               end else if (timeout_hit) begin
                  // A timed-out beat ends the whole command.
                  wbm_cyc_o <= 1'b0;
                  wbm_stb_o <= 1'b0;
                  rsp_dat   <= '0;
                  rsp_err   <= 1'b1;
                  rsp_last  <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 16'd1;
               end
            end
            RSP: begin
               if (rsp_ready && !rsp_last) begin
                  beat_cnt  <= beat_cnt - 8'd1;
                  wbm_adr_o <= wbm_adr_o + 32'd4;
                  wait_cnt  <= '0;
                  wbm_cyc_o <= 1'b1;
                  wbm_stb_o <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
